// File: rtl/sodor_instr_stim_gen.sv
// sodor_instr_stim_gen: seeded random RV32I instruction source for Sodor-class cores.
// It emits warm-up NOPs, then LFSR-derived R-type, I-type ALU and load words
// over a valid/ready handshake. It stops on an optional instruction budget.
// The same SEED always yields the same stream.
module sodor_instr_stim_gen #(
    parameter int          XLEN           = 32,
    parameter logic [31:0] SEED           = 32'h00000144,
    parameter int          WARMUP_NOPS    = 3,
    parameter int          MAX_INSTRS     = 0,
    parameter int          DMEM_ADDR_BITS = 6,
    parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic [1:0]      mode,
    input  logic            dep_en,
    input  logic            instr_ready,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [15:0]     gen_count,
    output logic            done
);

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;
    localparam logic [6:0]  OP_R      = 7'b0110011;
    localparam logic [6:0]  OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OP_LOAD   = 7'b0000011;
    localparam logic [11:0] ADDR_MASK = 12'((1 << DMEM_ADDR_BITS) - 1);
    localparam int          WARM_W    = (WARMUP_NOPS > 1) ? $clog2(WARMUP_NOPS) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_NOPS - 1);
    localparam logic [16:0] MAX_CNT   = 17'(MAX_INSTRS);

    if (XLEN != 32) begin : g_bad_xlen
        $error("sodor_instr_stim_gen: XLEN must be 32 for RV32I");
    end
    if (SEED == 32'h0) begin : g_bad_seed
        $error("sodor_instr_stim_gen: SEED must be nonzero or the LFSR locks up");
    end
    if (DMEM_ADDR_BITS < 1 || DMEM_ADDR_BITS > 12) begin : g_bad_addr
        $error("sodor_instr_stim_gen: DMEM_ADDR_BITS must fit the 12-bit load offset");
    end
    if (MAX_INSTRS < 0 || MAX_INSTRS > 65535) begin : g_bad_max
        $error("sodor_instr_stim_gen: MAX_INSTRS must fit the 16-bit counter");
    end

    typedef enum logic [2:0] {S_IDLE, S_WARMUP, S_GEN, S_PAUSE, S_DONE} state_t;

    state_t            r_state;
    logic [31:0]       r_lfsr;
    logic [4:0]        r_prev_rd;
    logic [15:0]       r_gen_count;
    logic [31:0]       r_instr;
    logic              r_valid;
    logic              r_done;
    logic [WARM_W-1:0] r_warm_cnt;

    logic        w_xfer;
    logic        w_last;
    logic [31:0] w_lfsr_next;
    logic [31:0] w_word_cur;
    logic [31:0] w_word_next;

    // Turns one LFSR state into an instruction word of the requested class.
    function automatic logic [31:0] build_word(input logic [31:0] l, input logic [4:0] prev_rd,
                                               input logic [1:0] mode_sel, input logic dep);
        // NOTE: every local gets a value up front so no path through the case leaves one undriven.
        logic [4:0]  rs1  = l[9:5];
        logic [2:0]  f3   = l[17:15];
        logic [11:0] imm  = l[29:18];
        logic [6:0]  f7   = 7'h00;
        logic [1:0]  kind = (mode_sel == 2'd3) ? l[31:30] : mode_sel;
        logic [31:0] word = NOP_WORD;
        if (dep && l[31]) rs1 = prev_rd;
        case (kind)
            2'd0: begin
                if (l[30] && (f3 == 3'd0 || f3 == 3'd5)) f7 = 7'h20;
                word = {f7, l[14:10], rs1, f3, l[4:0], OP_R};
            end
            2'd1: begin
                if (f3 == 3'd1)      imm[11:5] = 7'h00;
                else if (f3 == 3'd5) imm[11:5] = l[30] ? 7'h20 : 7'h00;
                word = {imm, rs1, f3, l[4:0], OP_IMM};
            end
            default: begin
                // Loads read from x0 plus a small aligned offset, so the dependency swap never applies.
                if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) f3 = 3'd2;
                imm = l[29:18] & ADDR_MASK;
                if (f3 == 3'd1 || f3 == 3'd5) imm[0]   = 1'b0;
                if (f3 == 3'd2)               imm[1:0] = 2'b00;
                word = {imm, 5'd0, f3, l[4:0], OP_LOAD};
            end
        endcase
        return word;
    endfunction

    assign w_xfer      = r_valid & instr_ready;
    assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
    assign w_last      = (MAX_INSTRS != 0) && ((17'(r_gen_count) + 17'd1) == MAX_CNT);
    // Word for a fresh entry into GEN, and the word that follows the one being accepted now.
    assign w_word_cur  = build_word(r_lfsr, r_prev_rd, mode, dep_en);
    assign w_word_next = build_word(w_lfsr_next, r_lfsr[4:0], mode, dep_en);

    // Sequencer: state, LFSR, counters and the registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_lfsr      <= SEED;
            r_prev_rd   <= 5'd0;
            r_gen_count <= 16'd0;
            r_instr     <= NOP_WORD;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
            r_warm_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads pre-edge state.
            case (r_state)
                S_IDLE: begin
                    if (WARMUP_NOPS != 0) begin
                        r_state <= S_WARMUP;
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b1;
                    end else if (en) begin
                        r_state <= S_GEN;
                        r_instr <= w_word_cur;
                        r_valid <= 1'b1;
                    end else begin
                        r_state <= S_PAUSE;
                    end
                end
                S_WARMUP: begin
                    if (w_xfer) begin
                        r_warm_cnt <= r_warm_cnt + 1'b1;
                        if (r_warm_cnt == WARM_LAST) begin
                            if (en) begin
                                r_state <= S_GEN;
                                r_instr <= w_word_cur;
                            end else begin
                                r_state <= S_PAUSE;
                                r_valid <= 1'b0;
                            end
                        end
                    end
                end
                S_GEN: begin
                    if (w_xfer) begin
                        r_gen_count <= (r_gen_count == 16'hFFFF) ? r_gen_count : r_gen_count + 16'd1;
                        r_lfsr      <= w_lfsr_next;
                        r_prev_rd   <= r_lfsr[4:0];
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_instr <= NOP_WORD;
                            r_done  <= 1'b1;
                        end else if (!en) begin
                            r_state <= S_PAUSE;
                            r_valid <= 1'b0;
                        end else begin
                            r_instr <= w_word_next;
                        end
                    end
                end
                S_PAUSE: begin
                    if (en) begin
                        r_state <= S_GEN;
                        r_instr <= w_word_cur;
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_instr <= NOP_WORD;
                    r_valid <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign instr_valid = r_valid;
    assign instr       = r_instr;
    assign gen_count   = r_gen_count;
    assign done        = r_done;

endmodule

// File: tb/tb_sodor_instr_stim_gen.sv
// Directed bench for sodor_instr_stim_gen: hand-computed streams from SEED 32'h144,
// plus stall, pause, budget and reset-restart sequences.
module tb_sodor_instr_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [1:0]  mode;
        logic        dep;
        logic [2:0]  idx;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic        dep_en = 1'b0;
    logic        instr_ready = 1'b1;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] gen_count;
    logic        done;

    logic        reset_b_n = 1'b0;
    logic        ready_b = 1'b1;
    logic        valid_b;
    logic [31:0] instr_b;
    logic [15:0] count_b;
    logic        done_b;

    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sodor_instr_stim_gen dut (
        .clk(clk), .reset_n(reset_n), .en(en), .mode(mode), .dep_en(dep_en),
        .instr_ready(instr_ready), .instr_valid(instr_valid), .instr(instr),
        .gen_count(gen_count), .done(done)
    );

    sodor_instr_stim_gen #(.WARMUP_NOPS(0), .MAX_INSTRS(5)) dut_b (
        .clk(clk), .reset_n(reset_b_n), .en(en), .mode(mode), .dep_en(dep_en),
        .instr_ready(ready_b), .instr_valid(valid_b), .instr(instr_b),
        .gen_count(count_b), .done(done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_row(input logic [1:0] m, input logic d,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] w4, input logic [31:0] w5,
                           input logic [31:0] w6, input logic [31:0] w7);
        logic [31:0] w [8];
        w = '{w0, w1, w2, w3, w4, w5, w6, w7};
        for (int k = 0; k < 8; k++) vecs.push_back('{m, d, 3'(k), w[k]});
    endtask

    // Waits (bounded) for valid, returns the presented word, and lets it transfer.
    task automatic take_word(output logic [31:0] w);
        int waited = 0;
        while (instr_valid !== 1'b1 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL take_word timeout: valid=%b, expected 1", instr_valid);
        end
        w = instr;
        @(posedge clk); #1;
    endtask

    // Resets the main instance (possibly mid-handshake) and consumes the warm-up NOPs.
    task automatic start_stream(input logic [1:0] m, input logic d);
        logic [31:0] w;
        reset_n     = 1'b0;
        mode        = m;
        dep_en      = d;
        en          = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("reset valid", 32'(instr_valid), 32'd0);
        check("reset instr", instr, NOP);
        check("reset gen_count", 32'(gen_count), 32'd0);
        check("reset done", 32'(done), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("valid after release", 32'(instr_valid), 32'd1);
        for (int k = 0; k < 3; k++) begin
            take_word(w);
            check($sformatf("warmup nop %0d", k), w, NOP);
        end
        check("gen_count after warmup", 32'(gen_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        int          seen_f3_1;
        int          seen_f3_5;

        add_row(2'd0, 1'b0, 32'h00050233, 32'h00028133, 32'h000108B3, 32'h000085B3,
                            32'h40000B33, 32'h400005B3, 32'h00000333, 32'h000041B3);
        add_row(2'd0, 1'b1, 32'h00050233, 32'h00028133, 32'h000108B3, 32'h000885B3,
                            32'h40058B33, 32'h400005B3, 32'h00058333, 32'h000041B3);
        add_row(2'd1, 1'b0, 32'h00050213, 32'h00028113, 32'h00010893, 32'h00808593,
                            32'h00C00B13, 32'h80600593, 32'hC0B00313, 32'h60504193);
        add_row(2'd2, 1'b0, 32'h00000203, 32'h00000103, 32'h00000883, 32'h00800583,
                            32'h00C00B03, 32'h00600583, 32'h00B00303, 32'h00504183);
        add_row(2'd2, 1'b1, 32'h00000203, 32'h00000103, 32'h00000883, 32'h00800583,
                            32'h00C00B03, 32'h00600583, 32'h00B00303, 32'h00504183);
        add_row(2'd3, 1'b0, 32'h00050233, 32'h00028133, 32'h000108B3, 32'h00800583,
                            32'h00C00B03, 32'h80600593, 32'h00B00303, 32'h60504193);

        repeat (2) @(posedge clk);
        #1;

        // Table: every row restarts from reset and must reproduce the hand-computed stream.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].idx == 3'd0) start_stream(vecs[i].mode, vecs[i].dep);
            take_word(w);
            check($sformatf("vec%0d m%0d d%0d word", i, vecs[i].mode, vecs[i].dep), w, vecs[i].exp);
            check($sformatf("vec%0d gen_count", i), 32'(gen_count), 32'(vecs[i].idx) + 32'd1);
        end

        // Stall for 5 cycles after two words, then pause via en.
        start_stream(2'd0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            take_word(w);
            check($sformatf("pre-stall word %0d", k), w, vecs[k].exp);
        end
        instr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("stall instr %0d", k), instr, 32'h000108B3);
            check($sformatf("stall valid %0d", k), 32'(instr_valid), 32'd1);
            check($sformatf("stall gen_count %0d", k), 32'(gen_count), 32'd2);
        end
        instr_ready = 1'b1;
        for (int k = 2; k < 5; k++) begin
            take_word(w);
            check($sformatf("post-stall word %0d", k), w, vecs[k].exp);
        end
        check("post-stall gen_count", 32'(gen_count), 32'd5);
        en = 1'b0;
        take_word(w);
        check("word before pause", w, 32'h400005B3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pause valid %0d", k), 32'(instr_valid), 32'd0);
            check($sformatf("pause gen_count %0d", k), 32'(gen_count), 32'd6);
            @(posedge clk); #1;
        end
        en = 1'b1;
        @(posedge clk); #1;
        check("resume valid", 32'(instr_valid), 32'd1);
        for (int k = 6; k < 8; k++) begin
            take_word(w);
            check($sformatf("post-pause word %0d", k), w, vecs[k].exp);
        end

        // I-type ALU shift-immediate legality over a long run.
        start_stream(2'd1, 1'b0);
        seen_f3_1 = 0;
        seen_f3_5 = 0;
        for (int k = 0; k < 2000; k++) begin
            take_word(w);
            check("itype opcode", 32'(w[6:0]), 32'h13);
            if (w[14:12] == 3'd1) begin
                seen_f3_1++;
                check("slli imm[11:5]", 32'(w[31:25]), 32'h00);
            end
            if (w[14:12] == 3'd5) begin
                seen_f3_5++;
                check("srli/srai imm[11:5] legal", 32'(w[31:25] == 7'h00 || w[31:25] == 7'h20), 32'd1);
            end
        end
        check("itype f3=1 occurred", 32'(seen_f3_1 > 0), 32'd1);
        check("itype f3=5 occurred", 32'(seen_f3_5 > 0), 32'd1);
        check("itype gen_count 2000", 32'(gen_count), 32'd2000);

        // Load offsets stay inside the 64-byte window and are naturally aligned.
        start_stream(2'd2, 1'b1);
        for (int k = 0; k < 2000; k++) begin
            take_word(w);
            check("load opcode", 32'(w[6:0]), 32'h03);
            check("load rs1", 32'(w[19:15]), 32'd0);
            check("load f3 legal", 32'(w[14:12] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}), 32'd1);
            check("load imm < 64", 32'(w[31:20] < 12'd64), 32'd1);
            if (w[14:12] == 3'd2) check("lw alignment", 32'(w[21:20]), 32'd0);
            if (w[14:12] == 3'd1 || w[14:12] == 3'd5) check("lh alignment", 32'(w[20]), 32'd0);
        end

        // Dependency stream, aborted mid-handshake by reset, must restart identically.
        start_stream(2'd0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            take_word(w);
            check($sformatf("dep pre-reset word %0d", k), w, vecs[8 + k].exp);
        end
        start_stream(2'd0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            take_word(w);
            check($sformatf("dep post-reset word %0d", k), w, vecs[8 + k].exp);
        end

        // Budgeted instance: no warm-up, exactly 5 random words, then NOPs with done.
        mode      = 2'd0;
        dep_en    = 1'b0;
        en        = 1'b1;
        ready_b   = 1'b1;
        reset_b_n = 1'b0;
        @(negedge clk);
        check("budget reset valid", 32'(valid_b), 32'd0);
        reset_b_n = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("budget valid %0d", k), 32'(valid_b), 32'd1);
            check($sformatf("budget done low %0d", k), 32'(done_b), 32'd0);
            check($sformatf("budget word %0d", k), instr_b, vecs[k].exp);
            @(posedge clk); #1;
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("done flag %0d", k), 32'(done_b), 32'd1);
            check($sformatf("done instr %0d", k), instr_b, NOP);
            check($sformatf("done valid %0d", k), 32'(valid_b), 32'd1);
            check($sformatf("done gen_count %0d", k), 32'(count_b), 32'd5);
            @(posedge clk); #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
